// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

endpackage

// File: rtl/full_adder_nand.sv
// One-bit full adder built only from 2-input NAND gates: two half-adder stages
// followed by a NAND-built OR of their carries.
module full_adder_nand (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    logic w_n1, w_n2, w_n3, w_s1, w_c1;
    logic w_m1, w_m2, w_m3, w_c2;
    logic w_c1_n, w_c2_n;

    // First half adder: a + b
    assign w_n1 = ~(i_a & i_b);
    assign w_n2 = ~(i_a & w_n1);
    assign w_n3 = ~(i_b & w_n1);
    assign w_s1 = ~(w_n2 & w_n3);
    assign w_c1 = ~(w_n1 & w_n1);

    // Second half adder: partial sum + carry in
    assign w_m1  = ~(w_s1 & i_cin);
    assign w_m2  = ~(w_s1 & w_m1);
    assign w_m3  = ~(i_cin & w_m1);
    assign o_sum = ~(w_m2 & w_m3);
    assign w_c2  = ~(w_m1 & w_m1);

    // c1 | c2 == ~(~c1 & ~c2)
    assign w_c1_n = ~(w_c1 & w_c1);
    assign w_c2_n = ~(w_c2 & w_c2);
    assign o_cout = ~(w_c1_n & w_c2_n);

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder: adds a and b one bit per cycle through a single full-adder cell,
// publishing sum/cout with a one-cycle done pulse after WIDTH processing cycles.
module bit_serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_a, r_b, r_acc, r_sum;
    logic               r_carry, r_cout;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_fa_sum, w_fa_cout, w_last;

    full_adder_nand u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_nxt = StRun;
            StRun:   if (w_last) w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                StRun: begin
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_acc   <= {w_fa_sum, r_acc[WIDTH-1:1]};
                    r_carry <= w_fa_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    // Publish only the complete result, on the edge that enters DONE
                    if (w_last) begin
                        r_sum  <= {w_fa_sum, r_acc[WIDTH-1:1]};
                        r_cout <= w_fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == StRun);
    assign done = (r_state == StDone);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Self-checking bench: transaction-level model compared every cycle, directed literal
// scenarios, and a randomized stream with mid-operation input changes and resets.
module tb_bit_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit x_mode = 1'b0;

    always #5 clk = ~clk;

    bit_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Transaction model: an accepted start yields a+b after W busy cycles, then one done cycle.
    int           m_left = 0;
    bit           m_done = 1'b0;
    logic [W:0]   m_pend = '0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_cout <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_sum  <= m_pend[W-1:0];
                m_cout <= m_pend[W];
            end
        end else if (start) begin
            m_pend <= {1'b0, a} + {1'b0, b};
            m_left <= int'(W);
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("busy", 32'(busy), 32'(m_left > 0));
            check("done", 32'(done), 32'(m_done));
            if (!x_mode) begin
                check("sum", 32'(sum), 32'(m_sum));
                check("cout", 32'(cout), 32'(m_cout));
            end else begin
                check("sum_hi_x", 32'(sum[W-1:4]), 32'd0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib);
        start = 1'b1;
        a     = ia;
        b     = ib;
        tick();
        start = 1'b0;
    endtask

    task automatic directed(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic [W-1:0] es, input logic ec);
        int nb = 0;
        int k  = 0;
        issue(ia, ib);
        while (done !== 1'b1 && k < 30) begin
            if (busy === 1'b1) nb++;
            tick();
            k++;
        end
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_busy_cycles"}, 32'(nb), 32'(W));
        check({name, "_sum"}, 32'(sum), 32'(es));
        check({name, "_cout"}, 32'(cout), 32'(ec));
        tick();
        check({name, "_done_single"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ax;
        int ndone;
        int prev;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        tick();

        directed("op0F_01", 8'h0F, 8'h01, 8'h10, 1'b0);
        directed("opFF_01", 8'hFF, 8'h01, 8'h00, 1'b1);
        repeat (3) tick();
        check("hold_sum", 32'(sum), 32'h00);
        check("hold_cout", 32'(cout), 32'd1);
        directed("opFF_FF", 8'hFF, 8'hFF, 8'hFE, 1'b1);

        // Start and operand changes during RUN must be ignored
        issue(8'hA5, 8'h5A);
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            if (k < 5) begin
                start = 1'b1;
                a     = 8'h00;
                b     = 8'h00;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done === 1'b1) ndone++;
        end
        check("ignore_start_dones", 32'(ndone), 32'd1);
        check("ignore_start_sum", 32'(sum), 32'hFF);
        check("ignore_start_cout", 32'(cout), 32'd0);

        // Reset in the 4th RUN cycle aborts with no done
        issue(8'h12, 8'h34);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        directed("after_abort", 8'h33, 8'h44, 8'h77, 1'b0);

        // start held high: back-to-back operations
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h01;
        ndone = 0;
        prev  = -1;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (done === 1'b1) begin
                ndone++;
                check("b2b_sum", 32'(sum), 32'h02);
                if (prev >= 0) check("b2b_spacing", 32'(k - prev), 32'd10);
                prev = k;
            end
        end
        check("b2b_pulses", 32'(ndone), 32'd4);
        start = 1'b0;
        repeat (15) tick();

        // Randomized stream: random starts, operand churn, occasional reset
        for (int k = 0; k < 3000; k++) begin
            start = ($urandom_range(0, 3) == 0);
            a     = W'($urandom);
            b     = W'($urandom);
            rst   = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (15) tick();

        // Unknown low nibble on a: timing unaffected, upper result bits clean
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        x_mode = 1'b1;
        tick();
        ax = 8'b0000_xxxx;
        begin
            int nb = 0;
            int k  = 0;
            issue(ax, 8'h00);
            while (done !== 1'b1 && k < 30) begin
                if (busy === 1'b1) nb++;
                tick();
                k++;
            end
            check("x_done", 32'(done), 32'd1);
            check("x_busy_cycles", 32'(nb), 32'(W));
            check("x_sum_hi", 32'(sum[7:4]), 32'h0);
        end
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
